// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared types and default constants for the Viterbi frame sequencer
package viterbi_pkg;

    typedef enum logic [2:0] {
        FILL,
        SEL,
        TBCLR,
        TRACE,
        OUT
    } frame_state_t;

    localparam int TB_DEPTH = 5;
    localparam int SYM_W    = 2;
    localparam int TB_WD    = 16;
    localparam int DEC_W    = TB_DEPTH * 2;

endpackage

// File: rtl/viterbi_frame_ctrl_if.sv
// rtl/viterbi_frame_ctrl_if.sv - symbol input and decoded-word output handshakes
interface viterbi_frame_ctrl_if #(
    parameter int SYM_W = viterbi_pkg::SYM_W,
    parameter int DEC_W = viterbi_pkg::DEC_W
);
    logic             sym_valid;
    logic             sym_ready;
    logic [SYM_W-1:0] sym;
    logic             dec_valid;
    logic             dec_ready;
    logic [DEC_W-1:0] dec_data;

    // front-end / consumer side
    modport master (
        output sym_valid, sym, dec_ready,
        input  sym_ready, dec_valid, dec_data
    );

    // frame controller side
    modport slave (
        input  sym_valid, sym, dec_ready,
        output sym_ready, dec_valid, dec_data
    );
endinterface

// File: rtl/viterbi_frame_ctrl_tb_watchdog.sv
// rtl/viterbi_frame_ctrl_tb_watchdog.sv - saturating traceback watchdog counter
module tb_watchdog #(
    parameter int CNT_W = 5,
    parameter int TERM  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             term
);
    logic [CNT_W-1:0] cnt;

    assign term = (cnt == CNT_W'(TERM));

    // count enabled cycles, holding at the terminal value so it never wraps
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && !term) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/viterbi_frame_ctrl.sv
// rtl/viterbi_frame_ctrl.sv - frame sequencer driving ACS, node-select and traceback enables
module viterbi_frame_ctrl #(
    parameter int TB_DEPTH = viterbi_pkg::TB_DEPTH,
    parameter int SYM_W    = viterbi_pkg::SYM_W,
    parameter int TB_WD    = viterbi_pkg::TB_WD
) (
    input  logic                    clk,
    input  logic                    rst,
    viterbi_frame_ctrl_if.slave     bus,
    output logic                    o_en_acs,
    output logic [SYM_W-1:0]        o_acs_sym,
    output logic                    o_en_sel,
    output logic                    o_tb_rst_n,
    output logic                    o_en_t,
    input  logic                    i_tb_done,
    input  logic [2*TB_DEPTH-1:0]   i_tb_data,
    output logic                    o_busy,
    output logic                    o_err
);
    import viterbi_pkg::*;

    localparam int SC_W   = $clog2(TB_DEPTH + 1);
    localparam int WD_W   = $clog2(TB_WD + 1);
    localparam int WORD_W = 2 * TB_DEPTH;

    frame_state_t      state, next_state;
    logic [SC_W-1:0]   sym_cnt, sym_cnt_d;
    logic              accept, last_sym, handshake, wd_term;

    logic              sym_ready_q, en_acs_q, en_sel_q, tb_rst_n_q, en_t_q;
    logic              dec_valid_q, busy_q, err_q;
    logic [SYM_W-1:0]  acs_sym_q;
    logic [WORD_W-1:0] dec_data_q;

    logic              sym_ready_d, en_acs_d, en_sel_d, tb_rst_n_d, en_t_d;
    logic              dec_valid_d, busy_d, err_d, capture;

    assign accept    = bus.sym_valid && sym_ready_q && (state == FILL);
    assign last_sym  = (sym_cnt == SC_W'(TB_DEPTH - 1));
    assign handshake = dec_valid_q && bus.dec_ready && (state == OUT);

    // watchdog restarts when the traceback unit is cleared and idles at zero in FILL
    tb_watchdog #(
        .CNT_W (WD_W),
        .TERM  (TB_WD)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == FILL),
        .load     (state == TBCLR),
        .load_val ('0),
        .en       (state == TRACE),
        .term     (wd_term)
    );

    // state and symbol counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            sym_cnt <= '0;
        end else begin
            state   <= next_state;
            sym_cnt <= sym_cnt_d;
        end
    end

    // next-state and symbol count; done takes priority over the watchdog expiring
    always_comb begin
        next_state = state;
        sym_cnt_d  = sym_cnt;
        case (state)
            FILL: begin
                if (accept) begin
                    sym_cnt_d = sym_cnt + SC_W'(1);
                    if (last_sym) begin
                        next_state = SEL;
                    end
                end
            end
            SEL:   next_state = TBCLR;
            TBCLR: next_state = TRACE;
            TRACE: begin
                if (i_tb_done) begin
                    next_state = OUT;
                end else if (wd_term) begin
                    next_state = FILL;
                end
            end
            OUT: begin
                if (handshake) begin
                    next_state = FILL;
                end
            end
            default: next_state = FILL;
        endcase
        if (state != FILL && next_state == FILL) begin
            sym_cnt_d = '0;
        end
    end

    // next values of the registered outputs, derived from the transition being taken
    always_comb begin
        sym_ready_d = (next_state == FILL);
        en_acs_d    = accept;
        en_sel_d    = (state == SEL);
        tb_rst_n_d  = (state != TBCLR);
        en_t_d      = (state == TRACE) && (next_state == TRACE);
        dec_valid_d = (next_state == OUT);
        capture     = (state == TRACE) && i_tb_done;
        busy_d      = !((next_state == FILL) && (sym_cnt_d == '0));
        err_d       = err_q || ((state == TRACE) && !i_tb_done && wd_term);
    end

    // output registers; reset drops every strobe and any pending word
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_ready_q <= 1'b0;
            en_acs_q    <= 1'b0;
            acs_sym_q   <= '0;
            en_sel_q    <= 1'b0;
            tb_rst_n_q  <= 1'b0;
            en_t_q      <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sym_ready_q <= sym_ready_d;
            en_acs_q    <= en_acs_d;
            en_sel_q    <= en_sel_d;
            tb_rst_n_q  <= tb_rst_n_d;
            en_t_q      <= en_t_d;
            dec_valid_q <= dec_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            if (accept) begin
                acs_sym_q <= bus.sym;
            end
            if (capture) begin
                dec_data_q <= i_tb_data;
            end
        end
    end

    assign bus.sym_ready = sym_ready_q;
    assign bus.dec_valid = dec_valid_q;
    assign bus.dec_data  = dec_data_q;
    assign o_en_acs      = en_acs_q;
    assign o_acs_sym     = acs_sym_q;
    assign o_en_sel      = en_sel_q;
    assign o_tb_rst_n    = tb_rst_n_q;
    assign o_en_t        = en_t_q;
    assign o_busy        = busy_q;
    assign o_err         = err_q;
endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// tb/tb_viterbi_frame_ctrl.sv - self-checking bench for viterbi_frame_ctrl
module tb_viterbi_frame_ctrl;
    localparam int DEPTH = viterbi_pkg::TB_DEPTH;
    localparam int WD    = viterbi_pkg::TB_WD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tb_done = 1'b0;
    logic [9:0] tb_data = '0;
    logic       en_acs, en_sel, tb_rst_n, en_t, busy, err;
    logic [1:0] acs_sym;

    viterbi_frame_ctrl_if bus ();

    viterbi_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_en_acs   (en_acs),
        .o_acs_sym  (acs_sym),
        .o_en_sel   (en_sel),
        .o_tb_rst_n (tb_rst_n),
        .o_en_t     (en_t),
        .i_tb_done  (tb_done),
        .i_tb_data  (tb_data),
        .o_busy     (busy),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    // event log of the enable outputs, sampled on the falling edge
    int         cyc = 0;
    int         acs_total = 0, sel_total = 0, clr_total = 0, ent_total = 0, ovl_total = 0;
    int         last_acs_cyc = 0, acs_rise_cyc = 0, sel_cyc = 0, clr_cyc = 0;
    logic       prev_acs = 1'b0;
    logic [1:0] acs_log [256];

    always @(negedge clk) begin
        cyc++;
        if (en_acs === 1'b1) begin
            acs_log[acs_total[7:0]] = acs_sym;
            acs_total++;
            last_acs_cyc = cyc;
            if (!prev_acs) acs_rise_cyc = cyc;
        end
        prev_acs = (en_acs === 1'b1);
        if (en_sel === 1'b1) begin
            sel_total++;
            sel_cyc = cyc;
        end
        if (tb_rst_n === 1'b0 && rst === 1'b0) begin
            clr_total++;
            clr_cyc = cyc;
        end
        if (en_t === 1'b1) ent_total++;
        if ((int'(en_acs) + int'(en_sel) + int'(en_t)) > 1 || (en_t === 1'b1 && tb_rst_n === 1'b0))
            ovl_total++;
    end

    int         checks = 0;
    int         passed = 0;
    logic       exp_err = 1'b0;
    logic [1:0] exp_syms [5];
    logic [1:0] nominal_syms [5] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11};
    int         base_acs, base_sel, base_clr, base_ent;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_ctrl", {bus.sym_ready, en_acs, en_sel, en_t, tb_rst_n, bus.dec_valid, busy, err}, 8'h00);
        check("rst_acs_sym", acs_sym, 2'b00);
        check("rst_dec_data", bus.dec_data, 10'h000);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctrl"}, {bus.sym_ready, en_acs, en_sel, en_t, tb_rst_n, bus.dec_valid, busy}, 7'b1000100);
        check({tag, "_err"}, err, exp_err);
    endtask

    // mode 0: valid every cycle, 1: valid toggling 1/0, 2: random valid
    task automatic send_syms(input int mode, input bit fixed);
        int   acc = 0;
        int   guard = 0;
        bit   ph = 1'b1;
        logic v, r;
        base_acs = acs_total;
        base_sel = sel_total;
        base_clr = clr_total;
        base_ent = ent_total;
        for (int i = 0; i < DEPTH; i++)
            exp_syms[i] = fixed ? nominal_syms[i] : 2'($urandom_range(0, 3));
        while (acc < DEPTH && guard < 64) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ph;
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.sym_valid = v;
            bus.sym       = exp_syms[acc];
            tb_done       = 1'($urandom_range(0, 1));
            tb_data       = 10'($urandom);
            r = bus.sym_ready;
            tick();
            guard++;
            ph = !ph;
            if (v && r) begin
                acc++;
                if (acc == 1) check("busy_after_first", busy, 1'b1);
            end
        end
        check("accepts", acc, DEPTH);
        tb_done       = 1'b0;
        bus.sym_valid = 1'b1;
        bus.sym       = 2'($urandom);
        check("ready_low_after_last", bus.sym_ready, 1'b0);
    endtask

    task automatic wait_trace(input bit contiguous);
        int         g = 0;
        logic [9:0] obs_v, exp_v;
        while (en_t !== 1'b1 && g < 12) begin
            tick();
            g++;
        end
        check("en_t_rise", en_t, 1'b1);
        check("acs_count", acs_total - base_acs, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            obs_v[9-2*i -: 2] = acs_log[8'(base_acs + i)];
            exp_v[9-2*i -: 2] = exp_syms[i];
        end
        check("acs_syms", obs_v, exp_v);
        check("sel_count", sel_total - base_sel, 1);
        check("sel_after_last_acs", sel_cyc - last_acs_cyc, 1);
        check("clr_count", clr_total - base_clr, 1);
        check("clr_after_sel", clr_cyc - sel_cyc, 1);
        check("en_t_follows_clr", cyc - clr_cyc, 0);
        if (contiguous) check("acs_back_to_back", last_acs_cyc - acs_rise_cyc, DEPTH - 1);
    endtask

    task automatic finish_frame(input int delay, input logic [9:0] word, input int rdy_delay);
        for (int i = 0; i < delay; i++) tick();
        check("en_t_held", en_t, 1'b1);
        bus.dec_ready = (rdy_delay == 0);
        tb_done = 1'b1;
        tb_data = word;
        tick();
        tb_done = 1'b0;
        tb_data = 10'($urandom);
        check("dec_valid_rise", bus.dec_valid, 1'b1);
        check("dec_data", bus.dec_data, word);
        check("en_t_drop", en_t, 1'b0);
        if (rdy_delay > 0) begin
            for (int i = 1; i < rdy_delay; i++) begin
                tick();
                check("bp_hold", {bus.dec_valid, bus.dec_data, bus.sym_ready, en_acs, en_sel, en_t},
                      {1'b1, word, 4'b0000});
            end
            bus.dec_ready = 1'b1;
        end
        tick();
        bus.dec_ready = 1'b0;
        bus.sym_valid = 1'b0;
        check_idle("after_out");
        check("en_t_cycles", ent_total - base_ent, delay + 1);
        check("acs_per_frame", acs_total - base_acs, DEPTH);
        check("no_overlap", ovl_total, 0);
    endtask

    task automatic random_frame();
        send_syms(2, 1'b0);
        wait_trace(1'b0);
        finish_frame($urandom_range(0, 12), 10'($urandom), $urandom_range(0, 4));
    endtask

    initial begin
        int n;
        int g;
        bus.sym_valid = 1'b0;
        bus.sym       = '0;
        bus.dec_ready = 1'b0;
        tick();
        tick();
        check_reset_state();
        rst = 1'b0;
        tick();
        check_idle("idle");

        // nominal frame
        send_syms(0, 1'b1);
        wait_trace(1'b1);
        finish_frame(7, 10'h2A5, 0);

        // stalled input and output back-pressure
        send_syms(1, 1'b0);
        wait_trace(1'b0);
        finish_frame($urandom_range(0, 12), 10'($urandom), 6);

        // watchdog expiry
        send_syms(0, 1'b0);
        wait_trace(1'b1);
        n = 1;
        g = 0;
        while (en_t === 1'b1 && g < 40) begin
            tick();
            g++;
            if (en_t === 1'b1) n++;
        end
        bus.sym_valid = 1'b0;
        exp_err = 1'b1;
        check("wd_en_t_cycles", n, WD);
        check("wd_no_valid", bus.dec_valid, 1'b0);
        check_idle("after_wd");

        // good frame with sticky error
        random_frame();

        // reset during TRACE
        send_syms(2, 1'b0);
        wait_trace(1'b0);
        tick();
        tick();
        bus.sym_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_state();
        rst = 1'b0;
        exp_err = 1'b0;
        tick();
        check_idle("after_rst_trace");
        random_frame();

        // reset during OUT
        send_syms(0, 1'b0);
        wait_trace(1'b1);
        tick();
        tb_done = 1'b1;
        tb_data = 10'($urandom);
        tick();
        tb_done = 1'b0;
        check("out_before_rst", bus.dec_valid, 1'b1);
        bus.sym_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_state();
        rst = 1'b0;
        tick();
        check_idle("after_rst_out");
        send_syms(1, 1'b0);
        wait_trace(1'b0);
        finish_frame($urandom_range(0, 12), 10'($urandom), $urandom_range(0, 4));

        for (int k = 0; k < 4; k++) random_frame();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
